// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-address bundle between the PC generator,
// instruction memory and the execute-stage redirect source.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();

  logic            stall;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            trap;
  logic            halt;
  logic            resume;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_step;
  logic            fetch_valid;
  logic            pending_valid;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    input  stall,
    input  redir_valid,
    input  redir_target,
    input  trap,
    input  halt,
    input  resume,
    output pc,
    output pc_plus_step,
    output fetch_valid,
    output pending_valid,
    output misalign_err,
    output misalign_addr
  );

  modport slave (
    output stall,
    output redir_valid,
    output redir_target,
    output trap,
    output halt,
    output resume,
    input  pc,
    input  pc_plus_step,
    input  fetch_valid,
    input  pending_valid,
    input  misalign_err,
    input  misalign_addr
  );

endinterface

// File: rtl/pc_gen.sv
// pc_gen: RV32I fetch-address generator with trap entry,
// redirects, a one-entry pending-redirect buffer and halt.
module pc_gen #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          STEP         = 4
) (
  input  logic      clk,
  input  logic      reset,
  pc_gen_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VECTOR);
  localparam logic [XLEN-1:0] STEP_X  = XLEN'(STEP);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic            mis_err;
  logic [XLEN-1:0] mis_addr;
  logic            misaligned;

  assign misaligned = (bus.redir_target % STEP_X) != '0;

  assign bus.pc            = pc;
  assign bus.pc_plus_step  = pc + STEP_X;
  assign bus.fetch_valid   = (state == RUN) && !bus.stall && !reset;
  assign bus.pending_valid = pend_valid;
  assign bus.misalign_err  = mis_err;
  assign bus.misalign_addr = mis_addr;

  // Next fetch address, pending buffer and run/halt state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RST_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      mis_err     <= 1'b0;
      mis_addr    <= '0;
    end else begin
      mis_err <= 1'b0;
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.trap) begin
            pc         <= TRAP_PC;
            pend_valid <= 1'b0;
          end else if (bus.redir_valid && misaligned) begin
            pc         <= TRAP_PC;
            pend_valid <= 1'b0;
            mis_err    <= 1'b1;
            mis_addr   <= bus.redir_target;
          end else begin
            if (bus.halt)
              state <= HALT;
            if (bus.redir_valid && bus.stall) begin
              pend_valid  <= 1'b1;
              pend_target <= bus.redir_target;
            end else if (bus.redir_valid) begin
              pc         <= bus.redir_target;
              pend_valid <= 1'b0;
            end else if (bus.stall) begin
              pc <= pc;
            end else if (pend_valid) begin
              pc         <= pend_target;
              pend_valid <= 1'b0;
            end else if (!bus.halt) begin
              pc <= pc + STEP_X;
            end
          end
        end
        HALT: begin
          if (bus.trap) begin
            state      <= RUN;
            pc         <= TRAP_PC;
            pend_valid <= 1'b0;
          end else begin
            if (bus.resume)
              state <= RUN;
            if (bus.redir_valid) begin
              pend_valid  <= 1'b1;
              pend_target <= bus.redir_target;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen with
// hand-computed expected fetch addresses.
module tb_pc_gen;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag,
                        input logic [31:0] exp_pc,
                        input logic exp_fv);
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_fv"}, 32'(bus.fetch_valid), 32'(exp_fv));
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    bus.stall        = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_target = '0;
    bus.trap         = 1'b0;
    bus.halt         = 1'b0;
    bus.resume       = 1'b0;

    repeat (3) tick();
    chk_pc("rst", 32'h0, 1'b0);
    chk("rst_pend", 32'(bus.pending_valid), 32'h0);
    chk("rst_merr", 32'(bus.misalign_err), 32'h0);
    chk("rst_maddr", bus.misalign_addr, 32'h0);

    reset = 1'b0;
    #1;
    chk_pc("boot", 32'h0, 1'b0);
    tick(); chk_pc("seq0", 32'h0, 1'b1);
    chk("seq0_ps", bus.pc_plus_step, 32'h4);
    tick(); chk_pc("seq4", 32'h4, 1'b1);
    tick(); chk_pc("seq8", 32'h8, 1'b1);
    tick(); chk_pc("seqc", 32'hC, 1'b1);
    tick(); chk_pc("seq10", 32'h10, 1'b1);

    bus.stall        = 1'b1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h40;
    #1;
    chk("stall_fv", 32'(bus.fetch_valid), 32'h0);
    tick();
    chk_pc("pend1", 32'h10, 1'b0);
    chk("pend1_v", 32'(bus.pending_valid), 32'h1);
    bus.redir_valid = 1'b0;
    tick(); chk("pend2", bus.pc, 32'h10);
    tick(); chk("pend3", bus.pc, 32'h10);
    chk("pend3_v", 32'(bus.pending_valid), 32'h1);
    bus.stall = 1'b0;
    tick();
    chk_pc("rel", 32'h40, 1'b1);
    chk("rel_v", 32'(bus.pending_valid), 32'h0);
    tick(); chk("rel_inc", bus.pc, 32'h44);

    bus.stall        = 1'b1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h40;
    tick();
    bus.redir_target = 32'h80;
    tick();
    chk("ow_hold", bus.pc, 32'h44);
    bus.redir_valid = 1'b0;
    bus.stall       = 1'b0;
    tick(); chk("ow_rel", bus.pc, 32'h80);

    bus.stall        = 1'b1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h40;
    tick();
    bus.redir_target = 32'h80;
    tick();
    bus.redir_valid = 1'b0;
    bus.trap        = 1'b1;
    tick();
    chk("trap_pc", bus.pc, 32'h100);
    chk("trap_pend", 32'(bus.pending_valid), 32'h0);
    bus.trap  = 1'b0;
    bus.stall = 1'b0;
    tick(); chk_pc("trap_inc", 32'h104, 1'b1);

    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h42;
    tick();
    chk("mis_pc", bus.pc, 32'h100);
    chk("mis_err", 32'(bus.misalign_err), 32'h1);
    chk("mis_addr", bus.misalign_addr, 32'h42);
    bus.redir_valid = 1'b0;
    tick();
    chk("mis_clr", 32'(bus.misalign_err), 32'h0);
    chk("mis_hold", bus.misalign_addr, 32'h42);
    chk("mis_inc", bus.pc, 32'h104);

    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'hFFFF_FFF8;
    tick(); chk("wrap_a", bus.pc, 32'hFFFF_FFF8);
    bus.redir_valid = 1'b0;
    tick(); chk("wrap_b", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_ps", bus.pc_plus_step, 32'h0);
    tick(); chk("wrap_c", bus.pc, 32'h0);

    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h20;
    tick(); chk("h_pre", bus.pc, 32'h20);
    bus.redir_valid = 1'b0;
    bus.halt        = 1'b1;
    tick(); chk_pc("halt0", 32'h20, 1'b0);
    bus.halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_pc("halt_n", 32'h20, 1'b0);
    end
    bus.resume = 1'b1;
    tick(); chk_pc("resume", 32'h20, 1'b1);
    bus.resume = 1'b0;
    tick(); chk_pc("res_inc", 32'h24, 1'b1);

    bus.halt = 1'b1;
    tick(); chk_pc("halt2", 32'h24, 1'b0);
    bus.halt   = 1'b0;
    bus.trap   = 1'b1;
    bus.resume = 1'b1;
    tick(); chk_pc("h_trap", 32'h100, 1'b1);
    bus.trap   = 1'b0;
    bus.resume = 1'b0;
    tick(); chk("h_trap_inc", bus.pc, 32'h104);

    reset = 1'b1;
    tick(); chk_pc("rst2", 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk_pc("boot2", 32'h0, 1'b0);
    tick(); chk_pc("run2", 32'h0, 1'b1);
    tick(); chk("run2_inc", bus.pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32I fetch stage, replacing the plain reset/load PC register. It owns the fetch address and applies, in fixed priority, trap entry, branch/jump redirects, a one-entry pending-redirect buffer for redirects arriving under stall, sequential increment, and a halt state. Misaligned redirect targets are trapped internally. Instruction memory reads `pc` when `fetch_valid` is high; the execute stage drives `redir_*`.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 0, PC value held during reset and boot
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect
- STEP, 4, sequential increment (bytes)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (downstream not ready)
- redir_valid  in  1  branch/jump taken this cycle
- redir_target  in  XLEN  redirect address
- trap  in  1  exception/ecall; forces TRAP_VECTOR
- halt  in  1  request entry to HALT
- resume  in  1  leave HALT, continue at held PC
- pc  out  XLEN  current fetch address
- pc_plus_step  out  XLEN  pc + STEP, combinational, wraps mod 2^XLEN
- fetch_valid  out  1  high only in RUN with stall low
- pending_valid  out  1  pending-redirect buffer occupied
- misalign_err  out  1  one-cycle pulse: redirect target not STEP-aligned
- misalign_addr  out  XLEN  offending target, held until next error

## Operation
- States: BOOT, RUN, HALT. Registered: state, pc, pend_valid, pend_target, misalign_err, misalign_addr.
- Reset: state=BOOT, pc=RESET_VECTOR, pend_valid=0, misalign_err=0, misalign_addr=0.
- BOOT: one cycle; all inputs ignored; next state RUN; pc unchanged (the first fetch is RESET_VECTOR).
- RUN next-PC priority, highest first:
  1. trap: pc=TRAP_VECTOR, clear pending; applies even when stalled.
  2. redir_valid and target misaligned (target mod STEP != 0): pc=TRAP_VECTOR, misalign_err=1 for one cycle, misalign_addr=target, clear pending; applies even when stalled.
  3. redir_valid, stall=1: pc holds; pend_target=target, pend_valid=1 (latest redirect overwrites).
  4. redir_valid, stall=0: pc=target, clear pending.
  5. stall=1: pc holds, pending unchanged.
  6. pend_valid, stall=0: pc=pend_target, clear pending.
  7. otherwise: pc = pc + STEP (wraps 0xFFFF_FFFC → 0).
- halt in RUN (priorities 1-2 not active): next state HALT; pc and pending keep the values from rules 3-7 for that cycle, except no increment (pc holds under rule 7).
- HALT: fetch_valid=0; pc holds. trap → RUN with pc=TRAP_VECTOR, pending cleared. resume → RUN, pc unchanged. redir_valid is captured into pending as under stall. trap beats resume.
- misalign_err deasserts the cycle after it pulses unless a new misaligned redirect occurs.

## Timing
- All outputs are registered except pc_plus_step (combinational from pc) and fetch_valid (combinational from state and stall).
- Redirect latency: redirect sampled at edge N; pc=target after edge N; first fetch of target in cycle N+1.
- Pending release: the first edge with stall=0 loads pend_target, provided no trap or redirect is active.
- Reset mid-operation overrides everything at the next edge, including pending and HALT. BOOT repeats.
- Outputs during reset: pc=RESET_VECTOR, fetch_valid=0, pending_valid=0, misalign_err=0.

## Test plan
- Reset release: hold reset 3 cycles, then release → pc=0 in BOOT (fetch_valid=0), then 0,4,8,12 with fetch_valid=1.
- Redirect under stall: at pc=0x10, stall=1 with redir_target=0x40, then stall 2 more cycles → pc stays 0x10 and pending_valid=1; stall drops → pc=0x40, pending_valid=0, then 0x44.
- Overwrite plus trap: while stalled, redirect 0x40 then 0x80 → pending=0x80; trap while still stalled → pc=0x100, pending_valid=0.
- Misaligned: redir_target=0x42 → pc=0x100, misalign_err pulses 1 cycle, misalign_addr=0x42.
- Wrap: pc=0xFFFF_FFF8 → 0xFFFF_FFFC, then 0x0000_0000; pc_plus_step=0 while pc=0xFFFF_FFFC.
- Halt/resume: halt at pc=0x20 → pc holds 0x20 with fetch_valid=0 for 5 cycles; resume → fetch 0x20, then 0x24. Trap asserted together with resume → pc=0x100.
